// File: rtl/uart_rx_operand_pkg.sv
// Shared definitions for the UART operand receiver: ASCII constants,
// deframer state encoding, default line parameters and hex helpers.
// Optional build macro: UART_RX_PARITY_EN (8E1 framing with a PARITY state).
package uart_rx_operand_pkg;

    localparam int DEF_CLK_FREQ = 100_000_000;
    localparam int DEF_BAUD     = 9600;

    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_NINE = 8'h39;
    localparam logic [7:0] ASCII_UC_A = 8'h41;
    localparam logic [7:0] ASCII_UC_F = 8'h46;
    localparam logic [7:0] ASCII_LC_A = 8'h61;
    localparam logic [7:0] ASCII_LC_F = 8'h66;

    // Deframer states; PARITY only exists in the 8E1 build.
    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        RX_PARITY = 3'd3,
`endif
        RX_STOP   = 3'd4
    } rx_state_e;

    function automatic logic is_hex(input logic [7:0] c);
        return ((c >= ASCII_ZERO) && (c <= ASCII_NINE)) ||
               ((c >= ASCII_UC_A) && (c <= ASCII_UC_F)) ||
               ((c >= ASCII_LC_A) && (c <= ASCII_LC_F));
    endfunction

    function automatic logic is_term(input logic [7:0] c);
        return (c == ASCII_CR) || (c == ASCII_LF);
    endfunction

    // Nibble value of a character already known to be a hex digit.
    function automatic logic [3:0] hex_nibble(input logic [7:0] c);
        logic [3:0] n;
        if (c <= ASCII_NINE) begin
            n = 4'(c - ASCII_ZERO);
        end else if (c <= ASCII_UC_F) begin
            n = 4'(c - 8'h37);
        end else begin
            n = 4'(c - 8'h57);
        end
        return n;
    endfunction

endpackage

// File: rtl/uart_rx_operand_byte.sv
// Byte deframer: 2-flop synchronizer, baud counter and deframer FSM.
// Emits rx_data/rx_valid for good frames and frame_err for a low stop bit.
// With UART_RX_PARITY_EN a PARITY state checks even parity (parity_err).
// Handshake: rx_valid is a single-cycle strobe with no ready; rx_data is
// valid in that cycle and holds its value until the next good byte.
module uart_rx_byte
    import uart_rx_operand_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err
`ifdef UART_RX_PARITY_EN
    , output logic     parity_err
`endif
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic          sync_1;
    logic          rxs;
    logic          armed;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          bit_tick;
    logic          half_tick;
`ifdef UART_RX_PARITY_EN
    logic          par_bad;
`endif

    // Current deframer state; kept as a named signal for checkers.
    rx_state_e     state;
    rx_state_e     state_next;

    assign bit_tick  = (cnt == BIT_LAST);
    assign half_tick = (cnt == HALF_LAST);

    // Two-flop synchronizer, preset to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1 <= 1'b1;
            rxs    <= 1'b1;
        end else begin
            sync_1 <= rxd;
            rxs    <= sync_1;
        end
    end

    // Deframer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RX_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a start is only taken once the line was seen high in IDLE.
    always_comb begin
        state_next = state;
        case (state)
            RX_IDLE: begin
                if (armed && !rxs) begin
                    state_next = RX_START;
                end
            end
            RX_START: begin
                if (half_tick) begin
                    state_next = rxs ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (bit_tick && (bit_idx == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    state_next = RX_PARITY;
`else
                    state_next = RX_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            RX_PARITY: begin
                if (bit_tick) begin
                    state_next = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                if (bit_tick) begin
                    state_next = RX_IDLE;
                end
            end
            default: state_next = RX_IDLE;
        endcase
    end

    // Baud counter, data shift register and registered result strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            armed     <= 1'b0;
            cnt       <= '0;
            bit_idx   <= 3'd0;
            shift     <= 8'd0;
            rx_data   <= 8'd0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            armed     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                RX_IDLE: begin
                    cnt     <= '0;
                    bit_idx <= 3'd0;
                    armed   <= rxs;
`ifdef UART_RX_PARITY_EN
                    par_bad <= 1'b0;
`endif
                end
                RX_START: begin
                    cnt <= half_tick ? '0 : cnt + CW'(1);
                end
                RX_DATA: begin
                    if (bit_tick) begin
                        cnt     <= '0;
                        shift   <= {rxs, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                RX_PARITY: begin
                    if (bit_tick) begin
                        cnt     <= '0;
                        par_bad <= rxs ^ (^shift);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`endif
                RX_STOP: begin
                    if (bit_tick) begin
                        cnt <= '0;
                        if (!rxs) begin
                            frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (par_bad) begin
                            parity_err <= 1'b1;
`endif
                        end else begin
                            rx_valid <= 1'b1;
                            rx_data  <= shift;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_operand.sv
// UART operand receiver: deframes serial bytes and assembles ASCII hex
// digits into a 64-bit right-justified operand, terminated by CR or LF.
// Optional build macro: UART_RX_PARITY_EN adds the parity_err output.
// Handshake: rx_valid and operand_valid are single-cycle strobes with no
// back-pressure; the data bus is valid in the strobe cycle and then held.
module uart_rx_operand
    import uart_rx_operand_pkg::*;
#(
    parameter int CLK_FREQ     = DEF_CLK_FREQ,
    parameter int BAUD         = DEF_BAUD,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        UART_RXD,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic [63:0] operand,
    output logic        operand_valid,
    output logic [4:0]  digit_count,
    output logic        frame_err,
    output logic        bad_char,
    output logic        overflow
`ifdef UART_RX_PARITY_EN
    , output logic      parity_err
`endif
);

    logic [63:0] acc;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk       (clk),
        .rst       (rst),
        .rxd       (UART_RXD),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err)
`ifdef UART_RX_PARITY_EN
        , .parity_err(parity_err)
`endif
    );

    // Hex parser: acts on each good byte the cycle after rx_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc           <= 64'd0;
            digit_count   <= 5'd0;
            operand       <= 64'd0;
            operand_valid <= 1'b0;
            bad_char      <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            operand_valid <= 1'b0;
            bad_char      <= 1'b0;
            if (rx_valid) begin
                if (is_hex(rx_data)) begin
                    if (digit_count != 5'd16) begin
                        acc         <= {acc[59:0], hex_nibble(rx_data)};
                        digit_count <= digit_count + 5'd1;
                    end else begin
                        overflow <= 1'b1;
                    end
                end else if (is_term(rx_data)) begin
                    // An empty line (e.g. the LF of a CR LF pair) is ignored.
                    if (digit_count != 5'd0) begin
                        operand       <= acc;
                        operand_valid <= 1'b1;
                        acc           <= 64'd0;
                        digit_count   <= 5'd0;
                        overflow      <= 1'b0;
                    end
                end else begin
                    bad_char    <= 1'b1;
                    acc         <= 64'd0;
                    digit_count <= 5'd0;
                    overflow    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_operand.sv
// Self-checking bench for uart_rx_operand with CLKS_PER_BIT = 16.
module tb_uart_rx_operand;
  import uart_rx_operand_pkg::*;

  localparam int CPB = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        uart_rxd;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [63:0] operand;
  logic        operand_valid;
  logic [4:0]  digit_count;
  logic        frame_err;
  logic        bad_char;
  logic        overflow;
`ifdef UART_RX_PARITY_EN
  logic        parity_err;
  logic        flip_parity = 1'b0;
`endif

  uart_rx_operand #(.CLKS_PER_BIT(CPB)) dut (
    .clk           (clk),
    .rst           (rst),
    .UART_RXD      (uart_rxd),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .operand       (operand),
    .operand_valid (operand_valid),
    .digit_count   (digit_count),
    .frame_err     (frame_err),
    .bad_char      (bad_char),
    .overflow      (overflow)
`ifdef UART_RX_PARITY_EN
    , .parity_err  (parity_err)
`endif
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0]  exp_q[$];
  logic [63:0] exp_op_q[$];
  int fe_seen = 0, bc_seen = 0, pe_seen = 0;
  int fe_exp = 0, bc_exp = 0, pe_exp = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected: got %h expected no byte", rx_data);
        end else begin
          check("rx_data", {56'd0, rx_data}, {56'd0, exp_q.pop_front()});
        end
      end
      if (operand_valid) begin
        if (exp_op_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL op_unexpected: got %h expected no operand", operand);
        end else begin
          check("operand", operand, exp_op_q.pop_front());
        end
      end
      if (frame_err) fe_seen++;
      if (bad_char)  bc_seen++;
`ifdef UART_RX_PARITY_EN
      if (parity_err) pe_seen++;
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    uart_rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    uart_rxd = (^b) ^ flip_parity;
    repeat (CPB) @(negedge clk);
`endif
    uart_rxd = stop_bit;
    repeat (CPB) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  // Good frame: the byte is expected on rx_data.
  task automatic send_char(input logic [7:0] b);
    exp_q.push_back(b);
    send_frame(b, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  string hex_str;

  initial begin
    rst = 1'b1;
    uart_rxd = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_rx_data", {56'd0, rx_data}, 64'd0);
    check("rst_rx_valid", {63'd0, rx_valid}, 64'd0);
    check("rst_operand", operand, 64'd0);
    check("rst_operand_valid", {63'd0, operand_valid}, 64'd0);
    check("rst_digit_count", {59'd0, digit_count}, 64'd0);
    check("rst_frame_err", {63'd0, frame_err}, 64'd0);
    check("rst_bad_char", {63'd0, bad_char}, 64'd0);
    check("rst_overflow", {63'd0, overflow}, 64'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_state_idle", 64'(dut.u_byte.state), 64'(RX_IDLE));

    // "1F\r" then a lone LF that must be ignored
    send_char("1");
    check("dc_after_1", {59'd0, digit_count}, 64'd1);
    send_char("F");
    check("dc_after_1F", {59'd0, digit_count}, 64'd2);
    exp_op_q.push_back(64'h1F);
    send_char(8'h0D);
    check("dc_after_cr", {59'd0, digit_count}, 64'd0);
    send_char(8'h0A);
    check("dc_after_lf", {59'd0, digit_count}, 64'd0);

    // 19 digits: the 17th sets overflow, the operand keeps the first 16
    hex_str = "FEDCBA9876543210abc";
    for (int i = 0; i < hex_str.len(); i++) begin
      send_char(hex_str[i]);
      if (i == 15) begin
        check("dc_at_16", {59'd0, digit_count}, 64'd16);
        check("ovf_at_16", {63'd0, overflow}, 64'd0);
      end
      if (i == 16) check("ovf_at_17", {63'd0, overflow}, 64'd1);
    end
    check("dc_saturated", {59'd0, digit_count}, 64'd16);
    exp_op_q.push_back(64'hFEDCBA9876543210);
    send_char(8'h0D);
    check("ovf_cleared", {63'd0, overflow}, 64'd0);
    check("dc_after_ovf_cr", {59'd0, digit_count}, 64'd0);

    // Framing error leaves the digit accumulator alone
    send_char("3");
    fe_exp++;
    send_frame(8'h41, 1'b0);
    check("frame_err_count", 64'(fe_seen), 64'(fe_exp));
    check("dc_after_frame_err", {59'd0, digit_count}, 64'd1);
    exp_op_q.push_back(64'h3);
    send_char(8'h0D);

    // 8-clock low glitch on the idle line
    uart_rxd = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("glitch_state_idle", 64'(dut.u_byte.state), 64'(RX_IDLE));
    check("glitch_no_frame_err", 64'(fe_seen), 64'(fe_exp));
    check("glitch_no_byte", 64'(exp_q.size()), 64'd0);

    // Bad character clears the accumulator
    send_char("1");
    send_char("2");
    bc_exp++;
    send_char("G");
    check("bad_char_count", 64'(bc_seen), 64'(bc_exp));
    check("dc_after_bad", {59'd0, digit_count}, 64'd0);
    send_char("7");
    exp_op_q.push_back(64'h7);
    send_char(8'h0A);

    // Reset during data bit 4 of "5", held until the frame has passed
    fork
      send_frame("5", 1'b1);
      begin
        repeat (5 * CPB + CPB / 2) @(negedge clk);
        rst = 1'b1;
      end
    join
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_dc", {59'd0, digit_count}, 64'd0);
    check("mid_rst_operand", operand, 64'd0);
    send_char("9");
    exp_op_q.push_back(64'h9);
    send_char(8'h0D);

`ifdef UART_RX_PARITY_EN
    // Wrong parity: byte is dropped before the parser
    flip_parity = 1'b1;
    pe_exp++;
    send_frame(8'h31, 1'b1);
    flip_parity = 1'b0;
    check("parity_err_count", 64'(pe_seen), 64'(pe_exp));
    check("dc_after_parity_err", {59'd0, digit_count}, 64'd0);
`endif

    repeat (CPB) @(negedge clk);
    check("final_rx_queue_empty", 64'(exp_q.size()), 64'd0);
    check("final_op_queue_empty", 64'(exp_op_q.size()), 64'd0);
    check("final_frame_err", 64'(fe_seen), 64'(fe_exp));
    check("final_bad_char", 64'(bc_seen), 64'(bc_exp));
    check("final_parity_err", 64'(pe_seen), 64'(pe_exp));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
